// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared FSM encodings, reset PC default and instruction width for the fetch stage.
package fetch_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int INSTR_W = 32;
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_FULL = 2'd1, S_DRAIN = 2'd2} state_e;
endpackage

// File: rtl/fetch_stage_skid.sv
// fetch_skid: one-entry {instr, pc} buffer catching a fetch that lands while decode is stalled.
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_i,
  output logic               full_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o
);
  logic               full_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i || unload_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end
  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS fetch PC, req/ack imem handshake and IF/ID register with skid and redirect drain.
// FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               id_stall,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);
  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d, drain_q, drain_d, ipc_q, ipc_d, pc4_q, pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d, skid_instr;
  logic [31:0]        skid_pc;
  logic               valid_q, valid_d, accept, skid_load, skid_full, ld_mem, ld_skid;
  assign accept    = !valid_q || !id_stall;
  assign imem_req  = !reset && state_q != S_FULL;
  assign imem_addr = state_q == S_DRAIN ? drain_q : pc_q;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drain_d   = drain_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    pc4_d     = pc4_q;
    skid_load = 1'b0;
    ld_mem    = 1'b0;
    ld_skid   = 1'b0;
    if (redirect) begin
      valid_d = 1'b0;
      pc_d    = redirect_pc & ~32'd3;
      state_d = (state_q != S_FULL && !imem_ack) ? S_DRAIN : S_FETCH;
      drain_d = state_q == S_FETCH ? pc_q : drain_q;
    end else if (state_q == S_FETCH) begin
      if (imem_ack) begin
        pc_d      = pc_q + 32'd4;
        ld_mem    = accept;
        skid_load = !accept;
        state_d   = accept ? S_FETCH : S_FULL;
      end else if (accept) begin
        valid_d = 1'b0;
      end
    end else if (state_q == S_FULL) begin
      if (!id_stall && skid_full) begin
        ld_skid = 1'b1;
        state_d = S_FETCH;
      end
    end else begin
      valid_d = 1'b0;
      state_d = imem_ack ? S_FETCH : S_DRAIN;
    end
    if (ld_mem) begin
      valid_d = 1'b1;
      instr_d = imem_rdata;
      ipc_d   = pc_q;
      pc4_d   = pc_q + 32'd4;
    end
    if (ld_skid) begin
      valid_d = 1'b1;
      instr_d = skid_instr;
      ipc_d   = skid_pc;
      pc4_d   = skid_pc + 32'd4;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      drain_q <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      pc4_q   <= pc4_d;
    end
  end
  fetch_skid u_skid (
    .clk      (clock),
    .rst      (reset),
    .load_i   (skid_load),
    .unload_i (ld_skid),
    .clear_i  (redirect),
    .instr_i  (imem_rdata),
    .pc_i     (pc_q),
    .full_o   (skid_full),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_pc4   = pc4_q;
`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, bubbles_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (ld_mem || ld_skid) fetched_q <= fetched_q + 32'd1;
      if (!valid_q) bubbles_q <= bubbles_q + 32'd1;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a variable-latency imem whose data is addr ^ 32'hDEAD_0000.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset, imem_req, imem_ack, redirect, id_stall, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_id_instr, if_id_pc, if_id_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif
  int total = 0;
  int bad = 0;
  int lat = 0;
  int cnt = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;
  assign imem_ack   = imem_req && (cnt == lat);
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;
  fetch_stage dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_stall    (id_stall),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_pc4", if_id_pc4, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf", perf_fetched | perf_bubbles, 32'd0);
`endif
    reset = 1'b0;
    #1;
    chk("zw_req", {31'd0, imem_req}, 32'd1);
    chk("zw_addr0", imem_addr, 32'h3000);
    tick();
    chk("zw_valid0", {31'd0, if_id_valid}, 32'd1);
    chk("zw_pc0", if_id_pc, 32'h3000);
    chk("zw_pc4_0", if_id_pc4, 32'h3004);
    chk("zw_instr0", if_id_instr, 32'hDEAD3000);
    tick();
    chk("zw_pc1", if_id_pc, 32'h3004);
    tick();
    chk("zw_pc2", if_id_pc, 32'h3008);
    chk("zw_pc4_2", if_id_pc4, 32'h300C);
    chk("zw_valid2", {31'd0, if_id_valid}, 32'd1);
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lat_bubble", {31'd0, if_id_valid}, 32'd0);
      chk("lat_addr", imem_addr, 32'h300C);
    end
    tick();
    chk("lat_valid", {31'd0, if_id_valid}, 32'd1);
    chk("lat_pc", if_id_pc, 32'h300C);
    chk("lat_next_addr", imem_addr, 32'h3010);
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pc", if_id_pc, 32'h300C);
    end
    tick();
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_valid", {31'd0, if_id_valid}, 32'd1);
    chk("full_pc", if_id_pc, 32'h300C);
    id_stall = 1'b0;
    tick();
    chk("rel_pc", if_id_pc, 32'h3010);
    chk("rel_instr", if_id_instr, 32'hDEAD3010);
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h3014);
    lat = 2; redirect = 1'b1; redirect_pc = 32'h4000;
    tick();
    redirect = 1'b0;
    chk("drain_addr", imem_addr, 32'h3014);
    chk("drain_valid", {31'd0, if_id_valid}, 32'd0);
    tick();
    chk("drain_valid2", {31'd0, if_id_valid}, 32'd0);
    tick();
    chk("redir_addr", imem_addr, 32'h4000);
    for (int i = 0; i < 3; i++) begin
      chk("redir_no_wrong", {31'd0, if_id_valid}, 32'd0);
      tick();
    end
    chk("redir_pc", if_id_pc, 32'h4000);
    chk("redir_instr", if_id_instr, 32'hDEAD4000);
    id_stall = 1'b1;
    tick(); tick();
    chk("coin_ack", {31'd0, imem_ack}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h5003;
    tick();
    redirect = 1'b0; id_stall = 1'b0; lat = 0;
    chk("coin_valid", {31'd0, if_id_valid}, 32'd0);
    chk("coin_addr", imem_addr, 32'h5000);
    tick();
    chk("coin_pc", if_id_pc, 32'h5000);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_addr2", imem_addr, 32'h0);
    tick();
    chk("wrap_pc0", if_id_pc, 32'h0);
    chk("wrap_pc4_0", if_id_pc4, 32'h4);
    lat = 5; redirect = 1'b1; redirect_pc = 32'h6000;
    tick();
    redirect = 1'b0;
    chk("rd_drain_addr", imem_addr, 32'h4);
    reset = 1'b1;
    tick();
    chk("rd_req", {31'd0, imem_req}, 32'd0);
    chk("rd_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rd_pc4", if_id_pc4, 32'd0);
    chk("rd_instr", if_id_instr, 32'd0);
    reset = 1'b0; lat = 0;
    #1;
    chk("rd_first_addr", imem_addr, 32'h3000);
    tick();
    chk("rd_first_pc", if_id_pc, 32'h3000);
    chk("rd_first_valid", {31'd0, if_id_valid}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
